// File: rtl/lcd_cfg_arbiter.sv
// Two-port round-robin arbiter in front of the LCD 3-wire configuration port.
// One 16-bit frame {adr, 2'b00, dat} is shifted out MSB first per grant; every
// phase (setup, each SCL half-bit, tail, gap) lasts HALF_PERIOD clocks.
module lcd_cfg_arbiter #(
  parameter int unsigned HALF_PERIOD = 5000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       req0_i,
  input  logic [5:0] adr0_i,
  input  logic [7:0] dat0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic [5:0] adr1_i,
  input  logic [7:0] dat1_i,
  output logic       ack1_o,
  output logic       busy_o,
  output logic       lcd_scen_o,
  output logic       lcd_scl_o,
  output logic       lcd_sda_o
);

  localparam int unsigned CntW = $clog2(HALF_PERIOD + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StBitLo,
    StBitHi,
    StTail,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_idx_q;
  logic [15:0]     shift_q;
  logic            owner_q;
  logic            last_q;
  logic            ack0_q, ack1_q;

  logic            elig0, elig1;
  logic            grant;
  logic            grant_port;
  logic            phase_done;

  // Eligibility masks the port acked this cycle, so the other port wins the
  // first IDLE cycle after a completion when it is pending.
  always_comb begin
    elig0      = req0_i & ~ack0_q;
    elig1      = req1_i & ~ack1_q;
    grant      = (state_q == StIdle) & (elig0 | elig1);
    grant_port = (elig0 & elig1) ? ~last_q : elig1;
    phase_done = (cnt_q == CntLast);
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every non-idle phase ends when the phase counter expires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (elig0 | elig1) state_d = StSetup;
      StSetup: if (phase_done) state_d = StBitLo;
      StBitLo: if (phase_done) state_d = StBitHi;
      StBitHi: if (phase_done) state_d = (bit_idx_q == 4'd15) ? StTail : StBitLo;
      StTail:  if (phase_done) state_d = StGap;
      StGap:   if (phase_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: phase counter, frame latch/shift, grant bookkeeping, ack pulses.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;

      if (state_q != state_d) begin
        cnt_q <= '0;
      end else if (state_q != StIdle) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (grant) begin
        shift_q   <= grant_port ? {adr1_i, 2'b00, dat1_i} : {adr0_i, 2'b00, dat0_i};
        owner_q   <= grant_port;
        last_q    <= grant_port;
        bit_idx_q <= '0;
      end

      if ((state_q == StBitHi) && phase_done) begin
        shift_q   <= {shift_q[14:0], 1'b0};
        bit_idx_q <= bit_idx_q + 4'd1;
      end

      if ((state_q == StGap) && phase_done) begin
        ack0_q <= ~owner_q;
        ack1_q <= owner_q;
      end
    end
  end

  // Serial pin and status decode; SDA follows shift_q[15] across the whole bit.
  always_comb begin
    busy_o     = (state_q != StIdle);
    lcd_scen_o = 1'b1;
    lcd_scl_o  = 1'b0;
    lcd_sda_o  = 1'b1;
    unique case (state_q)
      StSetup: begin
        lcd_scen_o = 1'b0;
      end
      StBitLo: begin
        lcd_scen_o = 1'b0;
        lcd_sda_o  = shift_q[15];
      end
      StBitHi: begin
        lcd_scen_o = 1'b0;
        lcd_scl_o  = 1'b1;
        lcd_sda_o  = shift_q[15];
      end
      StTail: begin
        lcd_scen_o = 1'b0;
        lcd_sda_o  = 1'b0;
      end
      default: ;
    endcase
  end

  assign ack0_o = ack0_q;
  assign ack1_o = ack1_q;

endmodule
